cntr_sched: RTL and testbench



---
 rtl/cntr_sched.sv | 263 ++++++++++++++++++++++++++
 tb/tb_cntr_sched.sv | 351 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cntr_sched.sv
// -----------------------------------------------------------------------------
// cntr_sched
//
// Round-robin scheduler that time-shares one reloadable down-counter between
// NREQ requesters. A requester raises req[i] with its reload value on
// req_load[i*WIDTH +: WIDTH]. The scheduler grants one requester at a time.
// It loads the counter by holding cnt_reset high for one cycle with the latched
// reload value on cnt_load, releases the counter, waits for cnt_tc, and then
// pulses done[i].
//
// Ports
//   clk        in   system clock, rising edge
//   reset      in   synchronous, active-high reset
//   req        in   [NREQ]        per-requester interval request (level)
//   req_load   in   [NREQ*WIDTH]  packed reload values, slice i for requester i
//   grant      out  [NREQ]        one-hot, high for the whole service
//   done       out  [NREQ]        one-cycle completion pulse
//   busy       out  1             high whenever a service is in progress
//   cnt_reset  out  1             counter reset/load strobe (loads while high)
//   cnt_load   out  [WIDTH]       reload value driven to the counter
//   err        out  1             timeout pulse (only with CNTR_SCHED_TIMEOUT_EN)
//   cnt_tc     in   1             counter terminal-count flag
//
// Optional feature
//   CNTR_SCHED_TIMEOUT_EN: when defined, a RUN cycle counter aborts a service
//   that has not seen cnt_tc after TIMEOUT cycles. The abort goes through DONE
//   and pulses err instead of done. When undefined, RUN waits indefinitely.
//
// All outputs are registered.
// -----------------------------------------------------------------------------
module cntr_sched #(
    parameter int NREQ    = 4,
    parameter int WIDTH   = 8,
    parameter int TIMEOUT = 300
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*WIDTH-1:0] req_load,
    output logic [NREQ-1:0]       grant,
    output logic [NREQ-1:0]       done,
    output logic                  busy,
    output logic                  cnt_reset,
    output logic [WIDTH-1:0]      cnt_load,
`ifdef CNTR_SCHED_TIMEOUT_EN
    output logic                  err,
`endif
    input  logic                  cnt_tc
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    // Reject parameter values outside the supported range at elaboration.
    generate
        if (NREQ < 2 || NREQ > 8 || WIDTH < 1 || TIMEOUT < 1) begin : g_param_check
            $error("cntr_sched: unsupported parameters NREQ=%0d WIDTH=%0d TIMEOUT=%0d",
                   NREQ, WIDTH, TIMEOUT);
        end
    endgenerate

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    state_t            state_q,     state_d;
    logic [PW-1:0]     ptr_q,       ptr_d;        // last requester served
    logic [PW-1:0]     cur_q,       cur_d;        // requester being served
    logic [NREQ-1:0]   grant_q,     grant_d;
    logic [NREQ-1:0]   done_q,      done_d;
    logic              busy_q,      busy_d;
    logic              cnt_reset_q, cnt_reset_d;
    logic [WIDTH-1:0]  cnt_load_q,  cnt_load_d;

    // -------------------------------------------------------------------------
    // Round-robin arbitration
    //
    // Searching upward from ptr+1 with wrap-around is the same as taking the
    // lowest set request strictly above ptr. If there is none, take the lowest
    // set request overall. After reset, ptr = NREQ-1, so no request is above
    // ptr and req[0] has the highest priority.
    // -------------------------------------------------------------------------
    logic [NREQ-1:0]   above_ptr;
    logic [NREQ-1:0]   req_hi;
    logic [NREQ-1:0]   pick_src;
    logic [NREQ-1:0]   pick_onehot;
    logic [PW-1:0]     pick_idx;
    logic              pick_valid;
    logic [WIDTH-1:0]  load_slice [NREQ];
    logic [WIDTH-1:0]  load_sel;

    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_req
            assign above_ptr[gi]   = (gi > int'(ptr_q));
            assign load_slice[gi]  = req_load[gi*WIDTH +: WIDTH];
            assign pick_onehot[gi] = (pick_idx == PW'(gi));
        end
    endgenerate

    assign req_hi     = req & above_ptr;
    assign pick_src   = (|req_hi) ? req_hi : req;
    assign pick_valid = |req;

    // Lowest set bit of pick_src; iterate downward so the lowest index wins.
    always_comb begin
        pick_idx = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (pick_src[i]) begin
                pick_idx = PW'(i);
            end
        end
    end

    assign load_sel = load_slice[pick_idx];

`ifdef CNTR_SCHED_TIMEOUT_EN
    // -------------------------------------------------------------------------
    // RUN watchdog. The counter is cleared on the LOAD->RUN transition, so it
    // holds 0 in the first RUN cycle. Checking for TIMEOUT-1 means the abort
    // fires when the count would reach TIMEOUT. err then appears exactly
    // TIMEOUT cycles after RUN entry.
    // -------------------------------------------------------------------------
    localparam int TW = $clog2(TIMEOUT + 1);

    logic [TW-1:0] timer_q, timer_d;
    logic          err_q,   err_d;
    logic          timeout_hit;

    assign timeout_hit = (timer_q == TW'(TIMEOUT - 1));
`endif

    // -------------------------------------------------------------------------
    // Next-state / next-output logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        cur_d       = cur_q;
        grant_d     = grant_q;
        done_d      = '0;
        busy_d      = busy_q;
        cnt_reset_d = cnt_reset_q;
        cnt_load_d  = cnt_load_q;
`ifdef CNTR_SCHED_TIMEOUT_EN
        timer_d     = timer_q;
        err_d       = 1'b0;
`endif

        case (state_q)
            ST_IDLE: begin
                cnt_reset_d = 1'b1;
                if (pick_valid) begin
                    // req_load is sampled only here; later changes are ignored
                    // until the next grant.
                    state_d    = ST_LOAD;
                    cur_d      = pick_idx;
                    grant_d    = pick_onehot;
                    cnt_load_d = load_sel;
                    busy_d     = 1'b1;
                end
            end

            ST_LOAD: begin
                // The counter loads during this single cycle. A stale cnt_tc
                // from the previous interval is ignored here.
                state_d     = ST_RUN;
                cnt_reset_d = 1'b0;
`ifdef CNTR_SCHED_TIMEOUT_EN
                timer_d     = '0;
`endif
            end

            ST_RUN: begin
                if (cnt_tc) begin
                    state_d = ST_DONE;
                    done_d  = grant_q;
                end
`ifdef CNTR_SCHED_TIMEOUT_EN
                else if (timeout_hit) begin
                    state_d = ST_DONE;
                    err_d   = 1'b1;
                end
                else begin
                    timer_d = timer_q + TW'(1);
                end
`endif
            end

            ST_DONE: begin
                // Record the served requester so it has lowest priority next.
                state_d     = ST_IDLE;
                ptr_d       = cur_q;
                grant_d     = '0;
                busy_d      = 1'b0;
                cnt_reset_d = 1'b1;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // State and output registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            ptr_q       <= PW'(NREQ - 1);
            cur_q       <= '0;
            grant_q     <= '0;
            done_q      <= '0;
            busy_q      <= 1'b0;
            cnt_reset_q <= 1'b1;
            cnt_load_q  <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            cur_q       <= cur_d;
            grant_q     <= grant_d;
            done_q      <= done_d;
            busy_q      <= busy_d;
            cnt_reset_q <= cnt_reset_d;
            cnt_load_q  <= cnt_load_d;
        end
    end

`ifdef CNTR_SCHED_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            timer_q <= '0;
            err_q   <= 1'b0;
        end else begin
            timer_q <= timer_d;
            err_q   <= err_d;
        end
    end

    assign err = err_q;
`endif

    assign grant     = grant_q;
    assign done      = done_q;
    assign busy      = busy_q;
    assign cnt_reset = cnt_reset_q;
    assign cnt_load  = cnt_load_q;

    // -------------------------------------------------------------------------
    // Structural invariants
    // -------------------------------------------------------------------------
    a_grant_onehot: assert property (@(posedge clk) disable iff (reset)
        $onehot0(grant_q));

    a_done_within_grant: assert property (@(posedge clk) disable iff (reset)
        ((done_q & ~grant_q) == '0));

    a_busy_matches_grant: assert property (@(posedge clk) disable iff (reset)
        (busy_q == (grant_q != '0)));

endmodule

// File: tb/tb_cntr_sched.sv
// -----------------------------------------------------------------------------
// tb_cntr_sched
//
// Directed bench for cntr_sched. The bench contains a behavioural model of the
// 8-bit reloadable down-counter. It also tracks services as transactions
// (who is served, how long since the grant, and whether the interval ended)
// and predicts every DUT output on every cycle. Hand-computed latencies,
// grant orders and values pin the model to the intended behaviour.
// -----------------------------------------------------------------------------
module tb_cntr_sched;

    localparam int NREQ  = 4;
    localparam int WIDTH = 8;
`ifdef CNTR_SCHED_TIMEOUT_EN
    localparam int TB_TIMEOUT = 40;
    localparam bit TO_EN      = 1'b1;
`else
    localparam int TB_TIMEOUT = 300;
    localparam bit TO_EN      = 1'b0;
`endif

    logic                  clk = 1'b0;
    logic                  reset = 1'b1;
    logic [NREQ-1:0]       req = 4'b0001;
    logic [NREQ*WIDTH-1:0] req_load = '0;
    logic [NREQ-1:0]       grant;
    logic [NREQ-1:0]       done;
    logic                  busy;
    logic                  cnt_reset;
    logic [WIDTH-1:0]      cnt_load;
    logic                  cnt_tc;
`ifdef CNTR_SCHED_TIMEOUT_EN
    logic                  err;
`endif

    int checks = 0;
    int errors = 0;

    cntr_sched #(
        .NREQ   (NREQ),
        .WIDTH  (WIDTH),
        .TIMEOUT(TB_TIMEOUT)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .req      (req),
        .req_load (req_load),
        .grant    (grant),
        .done     (done),
        .busy     (busy),
        .cnt_reset(cnt_reset),
        .cnt_load (cnt_load),
`ifdef CNTR_SCHED_TIMEOUT_EN
        .err      (err),
`endif
        .cnt_tc   (cnt_tc)
    );

    always #5 clk = ~clk;

    // ---------------- counter model (the cntr_8bit being shared) -------------
    logic [7:0] ctr_q = 8'hFF;
    bit         force_en  = 1'b0;
    bit         force_val = 1'b0;

    assign cnt_tc = force_en ? force_val : (ctr_q == 8'd0);

    always @(posedge clk) begin
        if (cnt_reset === 1'b1)
            ctr_q <= cnt_load;
        else if (ctr_q != 8'd0)
            ctr_q <= ctr_q - 8'd1;
    end

    // ---------------- transaction-level scheduler model -----------------------
    typedef struct {
        bit active;     // a requester holds the grant
        bit ending;     // this is the completion cycle
        bit timed_out;  // completion caused by the watchdog
        int k;          // requester being served
        int age;        // cycles since grant (0 = load cycle)
        int ptr;        // last requester served
        int load;       // latched reload value
    } model_t;

    model_t m;
    bit     started = 1'b0;
    int     cyc_cnt = 0;

    function automatic model_t step(model_t cur, bit rst, logic [NREQ-1:0] r,
                                    logic [NREQ*WIDTH-1:0] rl, bit tc);
        model_t n = cur;
        if (rst) begin
            n.active = 1'b0; n.ending = 1'b0; n.timed_out = 1'b0;
            n.k = 0; n.age = 0; n.ptr = NREQ - 1; n.load = 0;
            return n;
        end
        if (!cur.active) begin
            for (int i = 1; i <= NREQ; i++) begin
                int c;
                c = (cur.ptr + i) % NREQ;
                if (r[c] === 1'b1) begin
                    n.active = 1'b1;
                    n.k      = c;
                    n.age    = 0;
                    n.load   = int'(rl[c*WIDTH +: WIDTH]);
                    break;
                end
            end
        end else if (cur.ending) begin
            n.active = 1'b0; n.ending = 1'b0; n.timed_out = 1'b0;
            n.ptr = cur.k;
        end else begin
            n.age = cur.age + 1;
            if (cur.age >= 1) begin
                if (tc) begin
                    n.ending = 1'b1;
                end else if (TO_EN && cur.age == TB_TIMEOUT) begin
                    n.ending = 1'b1;
                    n.timed_out = 1'b1;
                end
            end
        end
        return n;
    endfunction

    function automatic logic [NREQ-1:0] oh_of(int k);
        logic [NREQ-1:0] v;
        v = '0;
        v[k] = 1'b1;
        return v;
    endfunction

    function automatic int idx_of(logic [NREQ-1:0] v);
        for (int i = 0; i < NREQ; i++)
            if (v[i]) return i;
        return -1;
    endfunction

    always @(posedge clk) begin
        m       <= step(m, reset === 1'b1, req, req_load, cnt_tc === 1'b1);
        started <= 1'b1;
        cyc_cnt <= cyc_cnt + 1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc_cnt);
        end
    endtask

    // ---------------- per-cycle compare ---------------------------------------
    always @(negedge clk) begin
        if (started) begin
            chk("cyc_grant", 32'(grant), 32'(m.active ? oh_of(m.k) : '0));
            chk("cyc_done", 32'(done),
                32'((m.active && m.ending && !m.timed_out) ? oh_of(m.k) : '0));
            chk("cyc_busy", 32'(busy), 32'(m.active));
            chk("cyc_cnt_reset", 32'(cnt_reset), 32'(!(m.active && m.age >= 1)));
            chk("cyc_cnt_load", 32'(cnt_load), 32'(WIDTH'(m.load)));
`ifdef CNTR_SCHED_TIMEOUT_EN
            chk("cyc_err", 32'(err), 32'(m.active && m.ending && m.timed_out));
`endif
        end
    end

    // ---------------- grant / done order recorder -----------------------------
    bit              rec_en = 1'b0;
    logic [NREQ-1:0] prev_grant = '0;
    int              q_g[$];
    int              q_t[$];
    int              q_d[$];

    always @(negedge clk) begin
        if (started && rec_en && grant != '0 && grant != prev_grant) begin
            q_g.push_back(idx_of(grant));
            q_t.push_back(cyc_cnt);
        end
        if (started && rec_en && done != '0)
            q_d.push_back(idx_of(done));
        prev_grant <= grant;
    end

    // ---------------- bounded waits -------------------------------------------
    // what: 0 grant!=0, 1 done!=0, 2 busy==0, 3 err==1
    function automatic bit cond(int what);
        case (what)
            0: return grant != '0;
            1: return done != '0;
            2: return busy == 1'b0;
`ifdef CNTR_SCHED_TIMEOUT_EN
            3: return err == 1'b1;
`endif
            default: return 1'b1;
        endcase
    endfunction

    task automatic wait_until(input int what, input int maxc, input string name,
                              output int cycles);
        cycles = 0;
        forever begin
            @(negedge clk);
            cycles++;
            if (cond(what)) return;
            if (cycles >= maxc) begin
                checks++;
                errors++;
                $display("FAIL %s: event not seen, waited %0d cycles, required within %0d",
                         name, cycles, maxc);
                return;
            end
        end
    endtask

    // ---------------- directed stimulus ---------------------------------------
    initial begin
        int n;
        int exp_order[5];
        exp_order = '{0, 1, 2, 3, 0};

        // 1) reset held 7 cycles with req[0] pending
        req_load[7:0] = 8'd20;
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            chk("rst_grant", 32'(grant), 32'h0);
            chk("rst_cnt_reset", 32'(cnt_reset), 32'h1);
            chk("rst_busy", 32'(busy), 32'h0);
        end
        reset = 1'b0;
        @(negedge clk);
        chk("t1_grant", 32'(grant), 32'h1);
        chk("t1_cnt_load", 32'(cnt_load), 32'd20);
        req = '0;                               // deassert mid-service
        wait_until(1, 60, "t1_done_wait", n);
        chk("t1_done_latency", n, 32'd22);
        chk("t1_done", 32'(done), 32'h1);
        @(negedge clk);
        chk("t1_grant_clear", 32'(grant), 32'h0);
        chk("t1_cnt_reset_back", 32'(cnt_reset), 32'h1);

        // 2) single requester 2, load 30; later load change must be ignored
        req_load[23:16] = 8'd30;
        req = 4'b0100;
        wait_until(0, 10, "t2_grant_wait", n);
        chk("t2_grant_latency", n, 32'd1);
        chk("t2_grant", 32'(grant), 32'h4);
        chk("t2_load_cycle_reset", 32'(cnt_reset), 32'h1);
        req = '0;
        req_load[23:16] = 8'd99;
        @(negedge clk);
        chk("t2_run_reset_low", 32'(cnt_reset), 32'h0);
        wait_until(1, 60, "t2_done_wait", n);
        chk("t2_done_latency", n, 32'd31);
        chk("t2_done", 32'(done), 32'h4);
        chk("t2_load_held", 32'(cnt_load), 32'd30);
        @(negedge clk);
        chk("t2_grant_clear", 32'(grant), 32'h0);

        // 3) all four requesting, loads 5/6/7/8, fresh pointer
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        req_load = {8'd8, 8'd7, 8'd6, 8'd5};
        rec_en = 1'b1;
        req = 4'b1111;
        for (int i = 0; i < 300 && q_g.size() < 5; i++) @(negedge clk);
        req = '0;
        wait_until(2, 40, "t3_idle_wait", n);
        rec_en = 1'b0;
        chk("t3_grant_count", q_g.size(), 32'd5);
        for (int i = 0; i < 5; i++) begin
            chk("t3_grant_order", (i < q_g.size()) ? q_g[i] : -1, exp_order[i]);
            chk("t3_done_order", (i < q_d.size()) ? q_d[i] : -1, exp_order[i]);
        end
        chk("t3_grant_interval", (q_t.size() > 1) ? q_t[1] - q_t[0] : -1, 32'd9);

        // 4) stale terminal count forced through IDLE and LOAD
        req_load[15:8] = 8'd3;
        force_en  = 1'b1;
        force_val = 1'b1;
        req = 4'b0010;
        wait_until(0, 10, "t4_grant_wait", n);
        chk("t4_grant", 32'(grant), 32'h2);
        req = '0;
        @(negedge clk);
        chk("t4_no_early_done", 32'(done), 32'h0);
        chk("t4_in_run", 32'(cnt_reset), 32'h0);
        force_en = 1'b0;
        wait_until(1, 20, "t4_done_wait", n);
        chk("t4_done_latency", n, 32'd4);
        chk("t4_done", 32'(done), 32'h2);
        wait_until(2, 10, "t4_idle_wait", n);

        // 5) reset pulse mid-RUN aborts; priority restarts from req[0]
        req_load[31:24] = 8'd50;
        req = 4'b1000;
        wait_until(0, 10, "t5_grant_wait", n);
        chk("t5_grant", 32'(grant), 32'h8);
        req = '0;
        repeat (5) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("t5_abort_grant", 32'(grant), 32'h0);
        chk("t5_abort_busy", 32'(busy), 32'h0);
        chk("t5_abort_cnt_reset", 32'(cnt_reset), 32'h1);
        chk("t5_abort_done", 32'(done), 32'h0);
        reset = 1'b0;
        req_load[15:8]  = 8'd2;
        req_load[31:24] = 8'd4;
        req = 4'b1010;
        @(negedge clk);
        chk("t5_restart_grant", 32'(grant), 32'h2);
        wait_until(1, 20, "t5_done_wait", n);
        chk("t5_done_latency", n, 32'd4);
        chk("t5_done", 32'(done), 32'h2);
        wait_until(0, 10, "t5_regrant_wait", n);
        chk("t5_regrant_latency", n, 32'd2);
        chk("t5_regrant", 32'(grant), 32'h8);
        req = '0;
        wait_until(2, 20, "t5_idle_wait", n);

`ifdef CNTR_SCHED_TIMEOUT_EN
        // 6) watchdog: terminal count never arrives
        req_load[7:0] = 8'd5;
        force_en  = 1'b1;
        force_val = 1'b0;
        req = 4'b0001;
        wait_until(0, 10, "t6_grant_wait", n);
        req = '0;
        wait_until(3, TB_TIMEOUT + 20, "t6_err_wait", n);
        chk("t6_err_latency", n, 32'(TB_TIMEOUT + 1));
        chk("t6_no_done", 32'(done), 32'h0);
        @(negedge clk);
        chk("t6_grant_clear", 32'(grant), 32'h0);
        force_en = 1'b0;
`endif

        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation still running at %0t, required to finish earlier", $time);
        $fatal(1);
    end

endmodule
